// File: rtl/apb_mem_backend_if.sv
// Request/response bundle between the APB slave FSM (master side) and the
// word-addressed memory backend (slave side).
interface apb_mem_backend_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 32
);
  logic                  req;
  logic                  we;
  logic [ADDR_W-1:0]     PADDR;
  logic [DATA_W-1:0]     PWDATA;
  logic [DATA_W/8-1:0]   PSTRB;
  logic                  rdata_valid;
  logic                  error;
  logic [DATA_W-1:0]     prdata_intr;

  modport master (
    output req, we, PADDR, PWDATA, PSTRB,
    input  rdata_valid, error, prdata_intr
  );

  modport slave (
    input  req, we, PADDR, PWDATA, PSTRB,
    output rdata_valid, error, prdata_intr
  );
endinterface

// File: rtl/apb_mem_backend.sv
// Word-addressed memory target behind the APB slave FSM: programmable wait
// states, per-byte-lane write strobes, and combinational address-fault flag.

// One byte lane of the whole array; the top instantiates one per PSTRB bit.
module apb_mem_backend_lane #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       wr_byte,
  output logic [7:0]       rd_byte
);
  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[idx] <= wr_byte;
    end
  end

  assign rd_byte = mem_q[idx];
endmodule

module apb_mem_backend #(
  parameter int DATA_W      = 64,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  apb_mem_backend_if.slave bus
);
  localparam int NUM_LANES = DATA_W / 8;
  localparam int OFF       = $clog2(NUM_LANES);
  localparam int IDX_W     = $clog2(DEPTH);
  localparam int WA_W      = ADDR_W - OFF;
  localparam logic [WA_W-1:0] DEPTH_LIM = WA_W'(DEPTH);
  localparam logic [3:0]      WS        = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                      state_q;
  logic [3:0]                  cnt_q;
  logic                        req_q;
  logic                        rdata_valid_q;
  logic [DATA_W-1:0]           prdata_q;

  logic [WA_W-1:0]             word_addr;
  logic [IDX_W-1:0]            idx;
  logic                        misaligned;
  logic                        oor;
  logic                        error_c;
  logic                        start;
  logic                        wr_commit;
  logic [DATA_W-1:0]           load_data;
  logic [NUM_LANES-1:0]        lane_we;
  logic [NUM_LANES-1:0][7:0]   wr_lanes;
  logic [NUM_LANES-1:0][7:0]   rd_lanes;

  assign word_addr = bus.PADDR[ADDR_W-1:OFF];
  assign idx       = word_addr[IDX_W-1:0];

  generate
    if (OFF == 0) begin : g_no_align
      assign misaligned = 1'b0;
    end else begin : g_align
      assign misaligned = |bus.PADDR[OFF-1:0];
    end
  endgenerate

  always_comb begin
    oor       = (word_addr >= DEPTH_LIM);
    error_c   = bus.req & (misaligned | oor);
    start     = bus.req & ~req_q;
    // Commit on the edge that closes the DONE cycle; FSM still holds req here.
    wr_commit = (state_q == DONE) & bus.we & ~error_c;
    load_data = error_c ? '0 : DATA_W'(rd_lanes);
    wr_lanes  = bus.PWDATA;
    lane_we   = {NUM_LANES{wr_commit}} & bus.PSTRB;
  end

  generate
    for (genvar b = 0; b < NUM_LANES; b++) begin : g_lane
      apb_mem_backend_lane #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
      ) u_lane (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .wr_en   (lane_we[b]),
        .idx     (idx),
        .wr_byte (wr_lanes[b]),
        .rd_byte (rd_lanes[b])
      );
    end
  endgenerate

  // Only a rising edge of req opens a transaction; DONE always falls back to IDLE.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      req_q         <= 1'b0;
      rdata_valid_q <= 1'b0;
      prdata_q      <= '0;
    end else begin
      req_q         <= bus.req;
      rdata_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_q <= WS;
            if (WS == 4'd0) begin
              state_q       <= DONE;
              rdata_valid_q <= 1'b1;
              prdata_q      <= load_data;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (!bus.req) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q       <= DONE;
              rdata_valid_q <= 1'b1;
              prdata_q      <= load_data;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.rdata_valid = rdata_valid_q;
  assign bus.error       = error_c;
  assign bus.prdata_intr = prdata_q;
endmodule
